// File: rtl/prio_enco_pkg.sv
// Shared widths and types for the registered priority encoder.
package prio_enco_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_IDX_W = $clog2(DEFAULT_WIDTH);

    typedef logic [DEFAULT_WIDTH-1:0] req_t;
    typedef logic [DEFAULT_IDX_W-1:0] idx_t;

endpackage

// File: rtl/prio_enco_tree.sv
// Combinational priority encoder: a log2(WIDTH)-deep tree of 2:1 priority nodes
// where the upper half always wins when it has any request.
module prio_enco_tree
    import prio_enco_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Heap layout: node k has children 2k (lower half) and 2k+1 (upper half);
    // leaves sit at WIDTH+i so the root is node 1.
    logic             nodeValid [2*WIDTH-1:1];
    logic [IDX_W-1:0] nodeIdx   [2*WIDTH-1:1];

    for (genvar i = 0; i < WIDTH; i++) begin : gLeaf
        assign nodeValid[WIDTH+i] = req_i[i];
        assign nodeIdx[WIDTH+i]   = '0;
    end

    // A node at depth d decides index bit IDX_W-1-d; an empty subtree carries
    // an all-zero index, so an idle request vector yields index 0.
    for (genvar d = 0; d < IDX_W; d++) begin : gLevel
        for (genvar j = 0; j < (1 << d); j++) begin : gNode
            localparam int K = (1 << d) + j;
            localparam logic [IDX_W-1:0] LEVEL_BIT = IDX_W'(1) << (IDX_W - 1 - d);

            assign nodeValid[K] = nodeValid[2*K+1] | nodeValid[2*K];
            assign nodeIdx[K]   = nodeValid[2*K+1] ? (nodeIdx[2*K+1] | LEVEL_BIT)
                                                   : nodeIdx[2*K];
        end
    end

    assign idx_o = nodeIdx[1];
    assign any_o = nodeValid[1];

endmodule

// File: rtl/prio_encoder.sv
// Registered WIDTH-input priority encoder (highest index wins), one cycle latency.
// Optional one-hot output enabled by defining PRIO_ENCO_ONEHOT_EN.
module prio_encoder
    import prio_enco_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    output logic [IDX_W-1:0] Y,
    output logic             valid
`ifdef PRIO_ENCO_ONEHOT_EN
    ,
    output logic [WIDTH-1:0] Y_onehot
`endif
);

    logic [IDX_W-1:0] encIdx;
    logic             encAny;

    logic [IDX_W-1:0] yIdx_d, yIdx_q;
    logic             valid_d, valid_q;

    prio_enco_tree #(
        .WIDTH (WIDTH)
    ) uTree (
        .req_i (A),
        .idx_o (encIdx),
        .any_o (encAny)
    );

    // The tree already returns index 0 for an idle vector; the explicit gate
    // keeps Y pinned to zero whenever valid is low regardless of tree internals.
    always_comb begin
        yIdx_d  = '0;
        valid_d = encAny;
        if (encAny) begin
            yIdx_d = encIdx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yIdx_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            yIdx_q  <= yIdx_d;
            valid_q <= valid_d;
        end
    end

    assign Y     = yIdx_q;
    assign valid = valid_q;

`ifdef PRIO_ENCO_ONEHOT_EN
    logic [WIDTH-1:0] onehot_d, onehot_q;

    always_comb begin
        onehot_d = '0;
        if (encAny) begin
            onehot_d = WIDTH'(1) << encIdx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_q <= '0;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign Y_onehot = onehot_q;
`endif

endmodule

// File: tb/tb_prio_encoder.sv
// Self-checking bench for prio_encoder: scoreboard of expected results pushed at
// stimulus time and popped one clock edge later.
module tb_prio_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [2:0] Y;
    logic       valid;
`ifdef PRIO_ENCO_ONEHOT_EN
    logic [7:0] Y_onehot;
`endif

    typedef struct {
        logic       vld;
        logic [2:0] idx;
        logic [7:0] oh;
        logic [7:0] req;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    prio_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .Y        (Y),
        .valid    (valid)
`ifdef PRIO_ENCO_ONEHOT_EN
        ,
        .Y_onehot (Y_onehot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: scan from bit 0 upward so the last set bit seen is the winner.
    function automatic exp_t modelResult(input logic [7:0] a);
        exp_t e;
        e.vld = 1'b0;
        e.idx = 3'd0;
        e.oh  = 8'h00;
        e.req = a;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) begin
                e.vld = 1'b1;
                e.idx = 3'(i);
                e.oh  = 8'h00;
                e.oh[i] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [7:0] a);
        A = a;
        expQ.push_back(modelResult(a));
    endtask

    task automatic sampleResult(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_valid"}, {31'd0, valid}, {31'd0, e.vld});
            checkOutput({tag, "_Y"}, {29'd0, Y}, {29'd0, e.idx});
`ifdef PRIO_ENCO_ONEHOT_EN
            checkOutput({tag, "_onehot"}, {24'd0, Y_onehot}, {24'd0, e.oh});
`endif
        end
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, valid}, 32'd0);
        checkOutput({tag, "_Y"}, {29'd0, Y}, 32'd0);
`ifdef PRIO_ENCO_ONEHOT_EN
        checkOutput({tag, "_onehot"}, {24'd0, Y_onehot}, 32'd0);
`endif
    endtask

    logic [7:0] prioVec [3];

    initial begin
        prioVec[0] = 8'hFF;
        prioVec[1] = 8'b0101_0110;
        prioVec[2] = 8'b0000_0011;

        rst_n = 1'b1;
        A     = 8'hFF;
        #1 rst_n = 1'b0;
        #2 checkCleared("reset_async");
        @(posedge clk);
        #1 checkCleared("reset_held");

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h00);
        sampleResult("zero");

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(8'h01 << i);
            sampleResult($sformatf("walk%0d", i));
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(prioVec[i]);
            sampleResult($sformatf("prio%0d", i));
        end

        @(negedge clk);
        applyStimulus(8'h80);
        sampleResult("pre_reset");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkCleared("midreset");
        applyStimulus(8'h04);
        #1 rst_n = 1'b1;
        sampleResult("post_reset");

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus((i % 2 == 0) ? 8'h00 : 8'h10);
            sampleResult($sformatf("b2b%0d", i));
        end

        @(negedge clk);
        A = 8'h80;
        #2 applyStimulus(8'h20);
        sampleResult("late_change");

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(8'($urandom_range(0, 255)));
            sampleResult($sformatf("rand%0d", i));
        end

        checkOutput("queue_empty", expQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
